// File: rtl/operand_issue_stage_pkg.sv
// operand_issue_stage_pkg: shared widths, issue bundle and register-mask helper
// Contents:
//   REG_IDX_W, XLEN, NUM_REGS  register-file geometry
//   CTRL_MAX_W                 widest control bundle the issue register can carry
//   issue_bundle_t             registered issue payload (operands, imm, rd, rd_we, ctrl)
//   reg_mask()                 one-hot register mask, index 0 never selected
package operand_issue_stage_pkg;
    localparam int REG_IDX_W  = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;
    localparam int CTRL_MAX_W = 32;

    typedef struct packed {
        logic [XLEN-1:0]       rs1_val;
        logic [XLEN-1:0]       rs2_val;
        logic [XLEN-1:0]       imm;
        logic [REG_IDX_W-1:0]  rd;
        logic                  rd_we;
        logic [CTRL_MAX_W-1:0] ctrl;
    } issue_bundle_t;

    // x0 is never tracked, so a zero index yields an empty mask
    function automatic logic [NUM_REGS-1:0] reg_mask(input logic en, input logic [REG_IDX_W-1:0] idx);
        reg_mask = (en && idx != '0) ? (NUM_REGS'(1) << idx) : '0;
    endfunction
endpackage

// File: rtl/operand_issue_stage_issue_scoreboard.sv
// issue_scoreboard: pending-write vector with set/clear ports and source hazard lookup
// Ports:
//   clock, async_reset               pipeline clock, asynchronous active-low reset
//   set_en_i / set_idx_i             mark a register as awaiting writeback (issue)
//   wb_clr_en_i / wb_clr_idx_i       writeback retires a pending register
//   flush_clr_en_i / flush_clr_idx_i flushed instruction releases its destination
//   rs1_i, rs2_i                     source indices to look up
//   busy1_o, busy2_o                 source still pending (hazard)
// Config: ISSUE_WB_BYPASS_EN hides pending bits cleared by a same-cycle writeback.
module issue_scoreboard
    import operand_issue_stage_pkg::*;
(
    input  logic                 clock,
    input  logic                 async_reset,
    input  logic                 set_en_i,
    input  logic [REG_IDX_W-1:0] set_idx_i,
    input  logic                 wb_clr_en_i,
    input  logic [REG_IDX_W-1:0] wb_clr_idx_i,
    input  logic                 flush_clr_en_i,
    input  logic [REG_IDX_W-1:0] flush_clr_idx_i,
    input  logic [REG_IDX_W-1:0] rs1_i,
    input  logic [REG_IDX_W-1:0] rs2_i,
    output logic                 busy1_o,
    output logic                 busy2_o
);
    logic [NUM_REGS-1:0] pending_q, pending_d, wb_mask, visible;

    assign wb_mask = reg_mask(wb_clr_en_i, wb_clr_idx_i);

    // clears apply first so a same-cycle set on the same index wins
    assign pending_d = ((pending_q & ~wb_mask & ~reg_mask(flush_clr_en_i, flush_clr_idx_i))
                        | reg_mask(set_en_i, set_idx_i)) & ~NUM_REGS'(1);

`ifdef ISSUE_WB_BYPASS_EN
    assign visible = pending_q & ~wb_mask;
`else
    assign visible = pending_q;
`endif

    assign busy1_o = visible[rs1_i];
    assign busy2_o = visible[rs2_i];

    always_ff @(posedge clock or negedge async_reset) begin
        if (!async_reset) pending_q <= '0;
        else pending_q <= pending_d;
    end
endmodule

// File: rtl/operand_issue_stage.sv
// operand_issue_stage: reads operands, tracks RAW hazards and issues decoded instructions to execute
// Ports:
//   clock, async_reset                      pipeline clock, asynchronous active-low reset
//   in_valid/in_ready, in_rs1/rs2/rd,
//   in_rd_we, in_imm, in_ctrl               decoded instruction from decode
//   read_addr_1/2, read_data_1/2            register-file read port (addresses follow in_rs1/in_rs2)
//   wb_valid, wb_addr, wb_data              writeback port image
//   flush                                   kill the instruction held in the output slot
//   out_valid/out_ready, out_*              registered issue slot to execute
// Config: define ISSUE_WB_BYPASS_EN to let a same-cycle writeback resolve a hazard and forward its data;
//         otherwise the instruction waits one more cycle and reads the register file.
module operand_issue_stage
    import operand_issue_stage_pkg::*;
#(
    parameter int CTRL_W = 8
) (
    input  logic              clock,
    input  logic              async_reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic              in_rd_we,
    input  logic [31:0]       in_imm,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic [4:0]        read_addr_1,
    output logic [4:0]        read_addr_2,
    input  logic [31:0]       read_data_1,
    input  logic [31:0]       read_data_2,
    input  logic              wb_valid,
    input  logic [4:0]        wb_addr,
    input  logic [31:0]       wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_rs1_val,
    output logic [31:0]       out_rs2_val,
    output logic [31:0]       out_imm,
    output logic [4:0]        out_rd,
    output logic              out_rd_we,
    output logic [CTRL_W-1:0] out_ctrl
);
    issue_bundle_t out_q, out_d;
    logic          out_valid_q, busy1, busy2, hazard, slot_free, issue;

    issue_scoreboard u_sb (
        .clock          (clock),
        .async_reset    (async_reset),
        .set_en_i       (issue && in_rd_we),
        .set_idx_i      (in_rd),
        .wb_clr_en_i    (wb_valid),
        .wb_clr_idx_i   (wb_addr),
        .flush_clr_en_i (flush && out_valid_q && out_q.rd_we),
        .flush_clr_idx_i(out_q.rd),
        .rs1_i          (in_rs1),
        .rs2_i          (in_rs2),
        .busy1_o        (busy1),
        .busy2_o        (busy2)
    );

    assign read_addr_1 = in_rs1;
    assign read_addr_2 = in_rs2;
    assign slot_free   = !out_valid_q || out_ready;
    assign hazard      = in_valid && (busy1 || busy2);
    assign in_ready    = slot_free && !hazard && !flush;
    assign issue       = in_valid && in_ready;

    // a writeback in flight is newer than the register-file read, whatever the build
    always_comb begin
        out_d.rs1_val = in_rs1 == '0 ? '0 : (wb_valid && wb_addr == in_rs1) ? wb_data : read_data_1;
        out_d.rs2_val = in_rs2 == '0 ? '0 : (wb_valid && wb_addr == in_rs2) ? wb_data : read_data_2;
        out_d.imm     = in_imm;
        out_d.rd      = in_rd;
        out_d.rd_we   = in_rd_we;
        out_d.ctrl    = CTRL_MAX_W'(in_ctrl);
    end

    always_ff @(posedge clock or negedge async_reset) begin
        if (!async_reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (issue) out_q <= out_d;
            out_valid_q <= issue || (out_valid_q && !out_ready && !flush);
        end
    end

    assign out_valid   = out_valid_q;
    assign out_rs1_val = out_q.rs1_val;
    assign out_rs2_val = out_q.rs2_val;
    assign out_imm     = out_q.imm;
    assign out_rd      = out_q.rd;
    assign out_rd_we   = out_q.rd_we;
    assign out_ctrl    = CTRL_W'(out_q.ctrl);
endmodule

// File: doc/operand_issue_stage.md
OPERAND_ISSUE_STAGE -- requirements
Module: operand_issue_stage

Interface
REQ-001 Parameter CTRL_W, default 8: width of opaque decoded-control bundle carried to execute.
REQ-002 clock  input  1  pipeline clock; all state updates on posedge.
REQ-003 async_reset  input  1  reset, asynchronous, active-low.
REQ-004 in_valid / in_ready  input / output  1 / 1  decoded-instruction handshake from decode.
REQ-005 in_rs1, in_rs2, in_rd  input  5 each  source/destination register indices.
REQ-006 in_rd_we, in_imm, in_ctrl  input  1 / 32 / CTRL_W  destination write flag, immediate, control bundle.
REQ-007 read_addr_1, read_addr_2  output  5 each  combinational copies of in_rs1/in_rs2 driven to the register file.
REQ-008 read_data_1, read_data_2  input  32 each  register-file read data; x0 reads as 0.
REQ-009 wb_valid, wb_addr, wb_data  input  1 / 5 / 32  writeback-port image, also driven into register-file write port.
REQ-010 flush  input  1  kill instruction held in output slot.
REQ-011 out_valid / out_ready  output / input  1 / 1  issue handshake to execute.
REQ-012 out_rs1_val, out_rs2_val, out_imm  output  32 each  registered operands and immediate.
REQ-013 out_rd, out_rd_we, out_ctrl  output  5 / 1 / CTRL_W  registered destination and control.

Function
REQ-014 Scoreboard: 32-bit pending vector, bit 0 hard-wired 0; bit n set means an issued instruction will write xn.
REQ-015 Hazard = in_valid and (pending[in_rs1] or pending[in_rs2]) after same-cycle wb clearing per REQ-021/REQ-022.
REQ-016 slot_free = !out_valid or out_ready; in_ready = slot_free and !hazard and !flush.
REQ-017 Issue fires when in_valid and in_ready; on that posedge output registers load, out_valid=1, pending[in_rd] set if in_rd_we and in_rd!=0.
REQ-018 Latency: one cycle from accepted input to out_valid; sustained throughput one per cycle with no hazards.
REQ-019 Output registers hold stable while out_valid and !out_ready; out_valid clears on out_ready without new issue.
REQ-020 wb_valid and wb_addr!=0 clears pending[wb_addr]; wb_addr=0 ignored.
REQ-021 Simultaneous issue setting and wb clearing the same index: set wins.
REQ-022 Operand mux: rsN==0 -> 0; else wb_valid and wb_addr==rsN -> wb_data (bypass per REQ-027); else read_data_N.
REQ-023 flush: out_valid cleared next posedge; if held slot has out_rd_we and out_rd!=0, its pending bit cleared (unless re-set by REQ-021 set rule, which cannot occur since in_ready=0); no issue that cycle; older already-consumed instructions' bits untouched.
REQ-024 in_rd_we with in_rd=0 issues normally, sets no bit.

Reset
REQ-025 async_reset low: pending=0, out_valid=0, out_rs1_val/out_rs2_val/out_imm=0, out_rd=0, out_rd_we=0, out_ctrl=0, immediately and regardless of clock.
REQ-026 Reset mid-stall discards held instruction; first posedge after release accepts input normally.

Configuration
REQ-027 Macro ISSUE_WB_BYPASS_EN defined: same-cycle wb to a pending source clears hazard and forwards wb_data; undefined: pending bit checked before wb clearing, instruction stalls one extra cycle and reads register file next cycle.

Structure
REQ-028 Shared package holds REG_IDX_W=5, XLEN=32, and a packed issue_bundle typedef (rs values, imm, rd, rd_we, ctrl).
REQ-029 One sub-module natural: issue_scoreboard (pending vector, set/clear, hazard lookup).

Verification
REQ-030 Reset then issue x1<=... (rd=1,rd_we=1), rs1=2 with read_data_1=0x5 -> next cycle out_rs1_val=0x5, pending[1]=1.
REQ-031 Following instr rs1=1 while pending[1] -> in_ready=0; wb_valid=1,wb_addr=1,wb_data=0xDEAD -> with macro issues same cycle, out_rs1_val=0xDEAD; without, issues one cycle later.
REQ-032 out_ready=0 for 3 cycles with out_valid=1 -> all outputs stable, in_ready=0; out_ready=1 -> back-to-back issue resumes.
REQ-033 Issue rd=7 then flush while held -> out_valid=0, pending[7]=0, later rs1=7 issues without stall.
REQ-034 Same-cycle issue rd=3 and wb_addr=3 -> pending[3]=1; rd=0 with rd_we=1 -> pending unchanged.
REQ-035 Assert async_reset mid-stall -> all outputs zero immediately; post-release issue completes in one cycle.
